// File: rtl/m_seven_segment_decoder_if.sv
// rtl/m_seven_segment_decoder_if.sv - display bus snoop and decoded-digit interface
interface m_seven_segment_decoder_if #(
  parameter int DIGITS = 8
);
  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] odat;
  logic [DIGITS-1:0]   point;
  logic [DIGITS-1:0]   digit_valid;
  logic                upd;
  logic [2:0]          upd_idx;
  logic                err;

  modport master (
    output seg_n, an_n,
    input  odat, point, digit_valid, upd, upd_idx, err
  );

  modport slave (
    input  seg_n, an_n,
    output odat, point, digit_valid, upd, upd_idx, err
  );
endinterface

// File: rtl/m_seven_segment_decoder.sv
// rtl/m_seven_segment_decoder.sv - 7-segment bus decoder with stability filter
// Optional macro SEVSEG_DEC_ALT_GLYPH_EN adds alternate 7, 9 and C glyphs.
module m_seven_segment_decoder #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  m_seven_segment_decoder_if.slave bus
);
  localparam int W  = DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [W-1:0]        s1, s2, s3;
  logic [CW-1:0]       cnt;
  logic                captured;
  logic [4*DIGITS-1:0] odat_r;
  logic [DIGITS-1:0]   point_r, valid_r;
  logic                upd_r, err_r;
  logic [2:0]          idx_r;

  logic                stable, fire, multi, hit, blank, dp;
  logic [DIGITS-1:0]   an_low;
  logic [2:0]          idx;
  logic [3:0]          val;

  function automatic logic [4:0] glyph(input logic [6:0] g);
    case (g)
      7'h40: glyph = 5'h10;
      7'h79: glyph = 5'h11;
      7'h24: glyph = 5'h12;
      7'h30: glyph = 5'h13;
      7'h19: glyph = 5'h14;
      7'h12: glyph = 5'h15;
      7'h02: glyph = 5'h16;
      7'h78: glyph = 5'h17;
      7'h00: glyph = 5'h18;
      7'h18: glyph = 5'h19;
      7'h08: glyph = 5'h1A;
      7'h03: glyph = 5'h1B;
      7'h27: glyph = 5'h1C;
      7'h21: glyph = 5'h1D;
      7'h06: glyph = 5'h1E;
      7'h0E: glyph = 5'h1F;
`ifdef SEVSEG_DEC_ALT_GLYPH_EN
      7'h10: glyph = 5'h19;
      7'h58: glyph = 5'h17;
      7'h46: glyph = 5'h1C;
`endif
      default: glyph = 5'h00;
    endcase
  endfunction

  always_comb begin
    stable = (s2 == s3);
    // Counter reaching STABLE_CYCLES-1 on this edge is the capture point.
    fire   = stable && !captured && (cnt == CW'(STABLE_CYCLES - 2));
    an_low = ~s2[W-1:8];
    multi  = (an_low & (an_low - DIGITS'(1))) != '0;
    idx    = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_low[i]) idx = 3'(i);
    end
    {hit, val} = glyph(s2[6:0]);
    blank  = (s2[6:0] == 7'h7F);
    dp     = ~s2[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '1;
      s2       <= '1;
      s3       <= '1;
      cnt      <= '0;
      captured <= 1'b0;
      odat_r   <= '0;
      point_r  <= '0;
      valid_r  <= '0;
      upd_r    <= 1'b0;
      err_r    <= 1'b0;
      idx_r    <= 3'd0;
    end else begin
      s1    <= {bus.an_n, bus.seg_n};
      s2    <= s1;
      s3    <= s2;
      upd_r <= 1'b0;
      err_r <= 1'b0;
      if (!stable) begin
        cnt      <= '0;
        captured <= 1'b0;
      end else if (cnt != CW'(STABLE_CYCLES - 1)) begin
        cnt <= cnt + CW'(1);
      end
      if (fire) begin
        captured <= 1'b1;
        if (multi) begin
          err_r <= 1'b1;
        end else if (an_low != '0) begin
          // Unrecognized glyphs report err alone so upd and err stay exclusive.
          upd_r <= hit || blank;
          err_r <= !(hit || blank);
          if (hit || blank) idx_r <= idx;
          for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) begin
              valid_r[i] <= hit;
              if (hit)        odat_r[4*i +: 4] <= val;
              else if (blank) odat_r[4*i +: 4] <= 4'd0;
              if (hit || blank) point_r[i] <= dp;
            end
          end
        end
      end
    end
  end

  assign bus.odat        = odat_r;
  assign bus.point       = point_r;
  assign bus.digit_valid = valid_r;
  assign bus.upd         = upd_r;
  assign bus.upd_idx     = idx_r;
  assign bus.err         = err_r;
endmodule
